memory_pager: RTL and testbench

Parametrised successor of the 48K memory block: a sequential memory mapper for the 128K-class machine with divMMC support. It holds the 7FFD paging register (RAM bank at C000, screen select, ROM select, lock) and the divMMC E3 control register, and runs the divMMC automap state machine on opcode fetches. It produces the external SRAM address, the write strobe and the ROM/divROM selects for the data mux. It sits between the CPU bus and the SRAM/ROM instances, on the CPU clock domain.

---
 rtl/memory_pager_if.sv | 31 +++
 rtl/memory_pager.sv | 195 +++++++++++++++++++
 tb/tb_memory_pager.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pager_if.sv
// CPU-side bus of the 128K/divMMC memory pager: Z80 strobes and clock enable in,
// SRAM address, write strobe, data-mux selects and paging status out.
interface memory_pager_if #(
    parameter int AW = 21
);
    logic          ce;
    logic          cpuMreq;
    logic          cpuIorq;
    logic          cpuM1;
    logic          cpuWr;
    logic [15:0]   cpuA;
    logic [7:0]    cpuDi;
    logic          romSel;
    logic          romPage;
    logic          divRomSel;
    logic          divMap;
    logic          vduPage;
    logic          ramWe;
    logic [AW-1:0] ramA;
    logic [1:0]    dbg_state;

    modport master (
        output ce, cpuMreq, cpuIorq, cpuM1, cpuWr, cpuA, cpuDi,
        input  romSel, romPage, divRomSel, divMap, vduPage, ramWe, ramA, dbg_state
    );

    modport slave (
        input  ce, cpuMreq, cpuIorq, cpuM1, cpuWr, cpuA, cpuDi,
        output romSel, romPage, divRomSel, divMap, vduPage, ramWe, ramA, dbg_state
    );
endinterface

// File: rtl/memory_pager.sv
// 128K memory mapper with divMMC: 7FFD paging, E3 control and the automap FSM,
// producing SRAM address/write strobe and ROM selects from the CPU bus.
module memory_pager #(
    parameter int BANK_W  = 3,
    parameter int DIV_PW  = 4,
    parameter int AW      = 21,
    parameter int AUTOMAP = 1
) (
    input  logic          clock,
    input  logic          reset,
    memory_pager_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_MAPPED = 2'd2;
    localparam logic [1:0] ST_UNARM  = 2'd3;

    logic [BANK_W-1:0] bank_q, bank_d, bank_di, win_bank;
    logic [DIV_PW-1:0] page_q, page_d;
    logic              vdu_page_q, vdu_page_d;
    logic              rom_page_q, rom_page_d;
    logic              lock_q, lock_d;
    logic              conmem_q, conmem_d;
    logic              mapram_q, mapram_d;
    logic [1:0]        state_q, state_d;
    logic              rearm_q, rearm_d;
    logic              io_wr_seen_q, io_wr_seen_d;
    logic              fetch_seen_q, fetch_seen_d;

    logic io_wr, fetch, io_wr_start, fetch_start;
    logic wr_7ffd, wr_e3;
    logic entry_hit, instant_hit, unmap_hit;
    logic div_map, rom_sel, div_rom_sel, read_only;
    logic [AW-1:0] ram_a;

    // Strobe "seen" flags advance only on ce, so only the first ce cycle of a strobe acts.
    assign io_wr       = !bus.cpuIorq && !bus.cpuWr;
    assign fetch       = !bus.cpuM1 && !bus.cpuMreq;
    assign io_wr_start = bus.ce && io_wr && !io_wr_seen_q;
    assign fetch_start = bus.ce && fetch && !fetch_seen_q;
    assign io_wr_seen_d = bus.ce ? io_wr : io_wr_seen_q;
    assign fetch_seen_d = bus.ce ? fetch : fetch_seen_q;

    assign wr_7ffd = io_wr_start && !bus.cpuA[15] && !bus.cpuA[1];
    assign wr_e3   = io_wr_start && (bus.cpuA[7:0] == 8'hE3);

    assign entry_hit   = (bus.cpuA == 16'h0000) || (bus.cpuA == 16'h0008) ||
                         (bus.cpuA == 16'h0038) || (bus.cpuA == 16'h0066) ||
                         (bus.cpuA == 16'h04C6) || (bus.cpuA == 16'h0562);
    assign instant_hit = (bus.cpuA[15:8] == 8'h3D);
    assign unmap_hit   = (bus.cpuA[15:3] == 13'h03FF);

    // Bank bits beyond the classic three come from cpuDi[7:6].
    always_comb begin
        bank_di = '0;
        for (int i = 0; i < BANK_W; i++) begin
            bank_di[i] = (i < 3) ? bus.cpuDi[i] : bus.cpuDi[i + 3];
        end
    end

    always_comb begin
        bank_d     = bank_q;
        vdu_page_d = vdu_page_q;
        rom_page_d = rom_page_q;
        lock_d     = lock_q;
        conmem_d   = conmem_q;
        mapram_d   = mapram_q;
        page_d     = page_q;
        if (wr_7ffd && !lock_q) begin
            bank_d     = bank_di;
            vdu_page_d = bus.cpuDi[3];
            rom_page_d = bus.cpuDi[4];
            lock_d     = bus.cpuDi[5];
        end
        if (wr_e3) begin
            conmem_d = bus.cpuDi[7];
            mapram_d = mapram_q | bus.cpuDi[6];
            page_d   = bus.cpuDi[DIV_PW-1:0];
        end
    end

    // ARM and UNARM wait for M1 to rise so the triggering fetch still sees the old map.
    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        if (bus.ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_start && entry_hit) begin
                        state_d = ST_ARM;
                    end else if (fetch_start && instant_hit) begin
                        state_d = ST_MAPPED;
                    end
                end
                ST_ARM: begin
                    if (bus.cpuM1) begin
                        state_d = ST_MAPPED;
                    end
                end
                ST_MAPPED: begin
                    rearm_d = 1'b0;
                    if (fetch_start && unmap_hit) begin
                        state_d = ST_UNARM;
                    end
                end
                default: begin
                    if (fetch_start && entry_hit) begin
                        rearm_d = 1'b1;
                    end
                    if (bus.cpuM1) begin
                        state_d = rearm_q ? ST_MAPPED : ST_IDLE;
                        rearm_d = 1'b0;
                    end
                end
            endcase
        end
        if (AUTOMAP == 0) begin
            state_d = ST_IDLE;
            rearm_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bank_q       <= '0;
            vdu_page_q   <= 1'b0;
            rom_page_q   <= 1'b0;
            lock_q       <= 1'b0;
            conmem_q     <= 1'b0;
            mapram_q     <= 1'b0;
            page_q       <= '0;
            state_q      <= ST_IDLE;
            rearm_q      <= 1'b0;
            // A strobe still active when reset releases must not trigger anything.
            io_wr_seen_q <= 1'b1;
            fetch_seen_q <= 1'b1;
        end else begin
            bank_q       <= bank_d;
            vdu_page_q   <= vdu_page_d;
            rom_page_q   <= rom_page_d;
            lock_q       <= lock_d;
            conmem_q     <= conmem_d;
            mapram_q     <= mapram_d;
            page_q       <= page_d;
            state_q      <= state_d;
            rearm_q      <= rearm_d;
            io_wr_seen_q <= io_wr_seen_d;
            fetch_seen_q <= fetch_seen_d;
        end
    end

    assign div_map = conmem_q || (state_q == ST_MAPPED) || (state_q == ST_UNARM);

    always_comb begin
        win_bank = bank_q;
        case (bus.cpuA[15:14])
            2'b01:   win_bank = BANK_W'(5);
            2'b10:   win_bank = BANK_W'(2);
            default: win_bank = bank_q;
        endcase
    end

    always_comb begin
        rom_sel     = 1'b0;
        div_rom_sel = 1'b0;
        read_only   = 1'b0;
        ram_a       = AW'({1'b0, win_bank, bus.cpuA[13:0]});
        if (bus.cpuA[15:14] == 2'b00) begin
            ram_a = '0;
            if (!div_map) begin
                rom_sel = 1'b1;
            end else if (!bus.cpuA[13]) begin
                if (conmem_q || !mapram_q) begin
                    div_rom_sel = 1'b1;
                end else begin
                    // mapram: page 3 stands in for the esxdos ROM and is write-protected.
                    ram_a     = AW'({1'b1, DIV_PW'(3), bus.cpuA[12:0]});
                    read_only = 1'b1;
                end
            end else begin
                ram_a     = AW'({1'b1, page_q, bus.cpuA[12:0]});
                read_only = mapram_q && !conmem_q && (page_q == DIV_PW'(3));
            end
        end
    end

    assign bus.romSel    = rom_sel;
    assign bus.divRomSel = div_rom_sel;
    assign bus.divMap    = div_map;
    assign bus.romPage   = rom_page_q;
    assign bus.vduPage   = vdu_page_q;
    assign bus.ramA      = ram_a;
    assign bus.ramWe     = bus.cpuWr | bus.cpuMreq | rom_sel | div_rom_sel | read_only;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_memory_pager.sv
// Bench for memory_pager: directed vector table, hand-written paging/automap sequences,
// and randomized bus traffic checked against a behavioural model of the memory map.
module tb_memory_pager;
    localparam int AW = 21;
    localparam int EW = AW + 6;

    logic clock = 1'b0;
    logic reset;

    memory_pager_if #(.AW(AW)) bus ();

    memory_pager #(
        .BANK_W (3),
        .DIV_PW (4),
        .AW     (AW),
        .AUTOMAP(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_bank, m_page;
    bit m_vdu, m_romp, m_lock, m_conmem, m_mapram;
    bit m_mapped, m_pend_map, m_pend_unmap, m_rearm;

    task automatic model_reset();
        m_bank = 0; m_page = 0;
        m_vdu = 0; m_romp = 0; m_lock = 0; m_conmem = 0; m_mapram = 0;
        m_mapped = 0; m_pend_map = 0; m_pend_unmap = 0; m_rearm = 0;
    endtask

    function automatic bit is_entry(input logic [15:0] a);
        return (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
               (a == 16'h0066) || (a == 16'h04C6) || (a == 16'h0562);
    endfunction

    task automatic model_io_write(input logic [15:0] a, input logic [7:0] d);
        if (!a[15] && !a[1] && !m_lock) begin
            m_bank = int'(d) % 8;
            m_vdu  = d[3];
            m_romp = d[4];
            m_lock = d[5];
        end
        if (a[7:0] == 8'hE3) begin
            m_conmem = d[7];
            if (d[6]) m_mapram = 1;
            m_page = int'(d) % 16;
        end
    endtask

    task automatic model_fetch(input logic [15:0] a);
        if (!m_mapped && !m_pend_map) begin
            if (is_entry(a)) m_pend_map = 1;
            else if (a >= 16'h3D00 && a <= 16'h3DFF) m_mapped = 1;
        end else if (m_mapped && !m_pend_unmap) begin
            if (a >= 16'h1FF8 && a <= 16'h1FFF) m_pend_unmap = 1;
        end else if (m_mapped && m_pend_unmap) begin
            if (is_entry(a)) m_rearm = 1;
        end
    endtask

    task automatic model_m1_high();
        if (m_pend_map) begin
            m_mapped = 1;
            m_pend_map = 0;
        end
        if (m_pend_unmap) begin
            m_mapped = m_rearm;
            m_pend_unmap = 0;
            m_rearm = 0;
        end
    endtask

    // Expected {divMap, romSel, divRomSel, ramWe, vduPage, romPage, ramA}.
    function automatic logic [EW-1:0] model_out(input logic [15:0] a, input bit wr_n, input bit mreq_n);
        bit dm, rs, drs, ro, we;
        int ra, bank, ai;
        ai = int'(a);
        dm = m_conmem | m_mapped;
        rs = 0; drs = 0; ro = 0; ra = 0;
        if (ai < 'h4000) begin
            if (!dm) rs = 1;
            else if (ai < 'h2000) begin
                if (m_conmem || !m_mapram) drs = 1;
                else begin
                    ra = 'h20000 + 3 * 'h2000 + ai;
                    ro = 1;
                end
            end else begin
                ra = 'h20000 + m_page * 'h2000 + (ai - 'h2000);
                ro = m_mapram && !m_conmem && (m_page == 3);
            end
        end else begin
            bank = (ai < 'h8000) ? 5 : (ai < 'hC000) ? 2 : m_bank;
            ra = bank * 'h4000 + (ai % 'h4000);
        end
        we = wr_n | mreq_n | rs | drs | ro;
        return {dm, rs, drs, we, m_vdu, m_romp, AW'(ra)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One or more cycles; ce random except the last, which always enables.
    task automatic run_cycles(input bit rand_ce);
        int n;
        n = rand_ce ? int'($urandom_range(1, 3)) : 1;
        for (int i = 0; i < n; i++) begin
            bus.ce = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        bus.ce = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        bus.ce = 1'($urandom_range(0, 1));
        tick();
        reset = 1'b1;
        bus.ce = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input bit rand_ce);
        bus.cpuA = a; bus.cpuDi = d; bus.cpuIorq = 1'b0; bus.cpuWr = 1'b0;
        run_cycles(rand_ce);
        model_io_write(a, d);
        bus.cpuIorq = 1'b1; bus.cpuWr = 1'b1;
        run_cycles(rand_ce);
    endtask

    task automatic fetch_start(input logic [15:0] a, input bit rand_ce);
        bus.cpuA = a; bus.cpuWr = 1'b1; bus.cpuM1 = 1'b0; bus.cpuMreq = 1'b0;
        run_cycles(rand_ce);
        model_fetch(a);
    endtask

    task automatic fetch_end(input bit rand_ce);
        bus.cpuM1 = 1'b1; bus.cpuMreq = 1'b1;
        run_cycles(rand_ce);
        model_m1_high();
    endtask

    task automatic access(input logic [15:0] a, input bit wr_n);
        bus.cpuA = a; bus.cpuWr = wr_n; bus.cpuMreq = 1'b0;
        #1;
    endtask

    task automatic release_bus();
        bus.cpuMreq = 1'b1; bus.cpuWr = 1'b1;
        #1;
    endtask

    // Compares every output against the model for the access currently on the bus.
    task automatic probe(input string tag, input logic [15:0] a, input bit wr_n, input bit keep);
        logic [EW-1:0] act, e;
        if (!keep) access(a, wr_n);
        else #1;
        exp_q.push_back(model_out(a, wr_n, 1'b0));
        act = {bus.divMap, bus.romSel, bus.divRomSel, bus.ramWe, bus.vduPage, bus.romPage, bus.ramA};
        e = exp_q.pop_front();
        check($sformatf("%s divMap @%h", tag, a),    32'(act[AW+5]), 32'(e[AW+5]));
        check($sformatf("%s romSel @%h", tag, a),    32'(act[AW+4]), 32'(e[AW+4]));
        check($sformatf("%s divRomSel @%h", tag, a), 32'(act[AW+3]), 32'(e[AW+3]));
        check($sformatf("%s ramWe @%h", tag, a),     32'(act[AW+2]), 32'(e[AW+2]));
        check($sformatf("%s vduPage", tag),          32'(act[AW+1]), 32'(e[AW+1]));
        check($sformatf("%s romPage", tag),          32'(act[AW]),   32'(e[AW]));
        if (!e[AW+4] && !e[AW+3])
            check($sformatf("%s ramA @%h", tag, a), 32'(act[AW-1:0]), 32'(e[AW-1:0]));
        if (!keep) release_bus();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]   a;
        bit            wr_n;
        bit            rs;
        bit            we;
        logic [AW-1:0] ra;
    } vec_t;

    vec_t vecs[8];

    logic [15:0] entries[6];

    initial begin
        logic [15:0] a;
        int op;

        // Bank 7 paged in, romPage=1, no divMMC mapping.
        vecs[0] = '{16'h0000, 1'b1, 1'b1, 1'b1, 21'h00000};
        vecs[1] = '{16'h3FFF, 1'b0, 1'b1, 1'b1, 21'h00000};
        vecs[2] = '{16'h4000, 1'b0, 1'b0, 1'b0, 21'h14000};
        vecs[3] = '{16'h5ABC, 1'b1, 1'b0, 1'b1, 21'h15ABC};
        vecs[4] = '{16'h8123, 1'b0, 1'b0, 1'b0, 21'h08123};
        vecs[5] = '{16'hBFFF, 1'b1, 1'b0, 1'b1, 21'h0BFFF};
        vecs[6] = '{16'hC000, 1'b0, 1'b0, 1'b0, 21'h1C000};
        vecs[7] = '{16'hF00D, 1'b1, 1'b0, 1'b1, 21'h1F00D};
        entries = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};

        bus.ce = 1'b1; bus.cpuMreq = 1'b1; bus.cpuIorq = 1'b1; bus.cpuM1 = 1'b1;
        bus.cpuWr = 1'b1; bus.cpuA = 16'h0000; bus.cpuDi = 8'h00;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        model_reset();

        // Reset state
        access(16'h0000, 1'b1);
        check("reset romSel", 32'(bus.romSel), 32'd1);
        check("reset divMap", 32'(bus.divMap), 32'd0);
        check("reset divRomSel", 32'(bus.divRomSel), 32'd0);
        access(16'hC000, 1'b1);
        check("reset ramA C000", 32'(bus.ramA), 32'h00000);
        check("reset romPage", 32'(bus.romPage), 32'd0);
        check("reset vduPage", 32'(bus.vduPage), 32'd0);
        release_bus();

        // 7FFD write and table
        io_write(16'h7FFD, 8'h17, 1'b0);
        check("7ffd romPage", 32'(bus.romPage), 32'd1);
        check("7ffd vduPage", 32'(bus.vduPage), 32'd0);
        for (int i = 0; i < 8; i++) begin
            access(vecs[i].a, vecs[i].wr_n);
            check($sformatf("vec%0d romSel", i), 32'(bus.romSel), 32'(vecs[i].rs));
            check($sformatf("vec%0d divRomSel", i), 32'(bus.divRomSel), 32'd0);
            check($sformatf("vec%0d ramWe", i), 32'(bus.ramWe), 32'(vecs[i].we));
            if (!vecs[i].rs)
                check($sformatf("vec%0d ramA", i), 32'(bus.ramA), 32'(vecs[i].ra));
            release_bus();
        end

        // Lock
        io_write(16'h7FFD, 8'h20, 1'b0);
        access(16'hC123, 1'b0);
        check("lock write bank0", 32'(bus.ramA), 32'h00123);
        check("lock write ramWe", 32'(bus.ramWe), 32'd0);
        check("lock write romPage", 32'(bus.romPage), 32'd0);
        release_bus();
        io_write(16'h7FFD, 8'h05, 1'b1);
        access(16'hC123, 1'b1);
        check("locked bank", 32'(bus.ramA), 32'h00123);
        check("locked vduPage", 32'(bus.vduPage), 32'd0);
        release_bus();

        // Delayed map at 0038
        fetch_start(16'h0038, 1'b1);
        check("delayed fetch romSel", 32'(bus.romSel), 32'd1);
        check("delayed fetch divMap", 32'(bus.divMap), 32'd0);
        fetch_end(1'b1);
        access(16'h0039, 1'b1);
        check("delayed after divRomSel", 32'(bus.divRomSel), 32'd1);
        check("delayed after divMap", 32'(bus.divMap), 32'd1);
        check("delayed after romSel", 32'(bus.romSel), 32'd0);
        release_bus();

        // Unmap at 1FF8
        fetch_start(16'h1FF8, 1'b1);
        check("unmap fetch divMap", 32'(bus.divMap), 32'd1);
        check("unmap fetch divRomSel", 32'(bus.divRomSel), 32'd1);
        fetch_end(1'b1);
        access(16'h0000, 1'b1);
        check("unmap after divMap", 32'(bus.divMap), 32'd0);
        check("unmap after romSel", 32'(bus.romSel), 32'd1);
        release_bus();

        // Instant map at 3D00
        fetch_start(16'h3D00, 1'b0);
        check("instant fetch divMap", 32'(bus.divMap), 32'd1);
        check("instant fetch romSel", 32'(bus.romSel), 32'd0);
        check("instant fetch ramA", 32'(bus.ramA), 32'h21D00);
        fetch_end(1'b0);
        check("instant after divMap", 32'(bus.divMap), 32'd1);
        fetch_start(16'h1FFC, 1'b0);
        fetch_end(1'b0);
        check("instant unmap divMap", 32'(bus.divMap), 32'd0);

        // Reset in the middle of an arming fetch
        fetch_start(16'h0066, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        fetch_end(1'b0);
        access(16'h0000, 1'b1);
        check("midfetch reset divMap", 32'(bus.divMap), 32'd0);
        check("midfetch reset romSel", 32'(bus.romSel), 32'd1);
        release_bus();

        // mapram protection
        io_write(16'h00E3, 8'h43, 1'b1);
        io_write(16'h00E3, 8'h01, 1'b1);
        fetch_start(16'h0000, 1'b1);
        fetch_end(1'b1);
        access(16'h0100, 1'b0);
        check("mapram ramA 0100", 32'(bus.ramA), 32'h26100);
        check("mapram ramWe 0100", 32'(bus.ramWe), 32'd1);
        check("mapram divRomSel", 32'(bus.divRomSel), 32'd0);
        access(16'h2000, 1'b0);
        check("mapram ramA 2000", 32'(bus.ramA), 32'h22000);
        check("mapram ramWe 2000", 32'(bus.ramWe), 32'd0);
        release_bus();

        // Reset from MAPPED with conmem and lock set
        io_write(16'h7FFD, 8'h21, 1'b0);
        io_write(16'h00E3, 8'h80, 1'b0);
        check("pre-reset divMap", 32'(bus.divMap), 32'd1);
        pulse_reset();
        access(16'h0000, 1'b1);
        check("post-reset divMap", 32'(bus.divMap), 32'd0);
        check("post-reset romSel", 32'(bus.romSel), 32'd1);
        access(16'hC000, 1'b0);
        check("post-reset bank", 32'(bus.ramA), 32'h00000);
        release_bus();
        io_write(16'h7FFD, 8'h03, 1'b0);
        access(16'hC010, 1'b0);
        check("post-reset 7ffd accepted", 32'(bus.ramA), 32'h0C010);
        release_bus();
        fetch_start(16'h0008, 1'b0);
        fetch_end(1'b0);
        access(16'h0100, 1'b1);
        check("post-reset mapram cleared", 32'(bus.divRomSel), 32'd1);
        release_bus();

        // Randomized traffic against the model
        pulse_reset();
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 19));
            case (op)
                0, 1, 2:  io_write(16'h7FFD, 8'($urandom_range(0, 255)) & ((n % 40 == 39) ? 8'hFF : 8'hDF), 1'b1);
                3, 4:     io_write(16'h00E3, 8'($urandom_range(0, 255)) & ((n % 50 == 49) ? 8'hFF : 8'hBF), 1'b1);
                5:        io_write(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 1'b1);
                6, 7, 8:  begin
                    fetch_start(entries[$urandom_range(0, 5)], 1'b1);
                    fetch_end(1'b1);
                end
                9, 10:    begin
                    fetch_start(16'h3D00 + 16'($urandom_range(0, 255)), 1'b1);
                    fetch_end(1'b1);
                end
                11, 12, 13: begin
                    a = 16'h1FF8 + 16'($urandom_range(0, 7));
                    fetch_start(a, 1'b1);
                    probe("rnd mid-unmap", a, 1'b1, 1'b1);
                    fetch_end(1'b1);
                end
                14, 15:   begin
                    fetch_start(16'($urandom_range(0, 65535)), 1'b1);
                    fetch_end(1'b1);
                end
                16:       pulse_reset();
                default:  run_cycles(1'b1);
            endcase
            for (int k = 0; k < 2; k++) begin
                a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'h3FFF))
                                                : 16'($urandom_range(0, 65535));
                probe("rnd", a, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
